arbiter_fsm: RTL and testbench
==============================

# arbiter_fsm

Control stage of the 3-requester round-robin arbiter. It samples requests, issues one-hot registered grants and holds each grant until release. It reads the stored eligibility mask from the priority register (`prio_q_i`) and drives that register's next value and enable (`prio_d_o`, `prio_en_o`). An optional watchdog revokes grants held too long.

## Interface
- `MAX_HOLD`, default 8: maximum grant cycles before forced revoke. Used only with `ARB_TIMEOUT_EN`. Legal range 2..255.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_i` in 3: request per requester; bit k = requester k.
- `release_i` in 1: current grant holder finished; ignored in IDLE.
- `prio_q_i` in 3: stored eligibility mask; bit=1 means eligible this round.
- `grant_o` out 3: one-hot grant, registered; 000 = none.
- `busy_o` out 1: state is GRANT.
- `prio_d_o` out 3: next mask, combinational.
- `prio_en_o` out 1: mask write strobe, combinational.
- `timeout_o` out 1: one-cycle pulse on forced revoke. Tied 0 without the macro.

## Operation
States:
- IDLE: no grant.
- GRANT: `grant_o` holds the selected requester.

Selection (combinational, evaluated in IDLE):
- `masked = req_i & prio_q_i`.
- If `masked != 0`: `sel` = lowest set bit of `masked`; `prio_d_o = prio_q_i & ~sel`.
- Else: `sel` = lowest set bit of `req_i`; `prio_d_o = 3'b111 & ~sel`.
- If the resulting `prio_d_o == 000`, drive 111 instead (new round).
- `prio_en_o = (state==IDLE) && (req_i != 0) && rst`.
- `prio_d_o` is don't-care when `prio_en_o = 0`.

Transitions:
- IDLE -> GRANT when `req_i != 0`. `grant_o <= sel` at the same edge the mask register loads `prio_d_o`.
- GRANT -> IDLE when any of the following holds; `grant_o <= 000`:
  - `release_i = 1`, or
  - the granted `req_i` bit = 0 (implicit release), or
  - timeout (macro only).
- GRANT never switches directly to another grant. One IDLE turnaround cycle always separates grants.

Boundary rules:
- Release and timeout in the same cycle: release wins, `timeout_o` stays 0.
- Requests changing while in GRANT are ignored until IDLE.
- `req_i = 000` in IDLE: stay in IDLE, `prio_en_o = 0`, mask unchanged.
- Reset mid-grant: `grant_o`, `busy_o`, `timeout_o` go to 0 immediately, state goes to IDLE, hold counter clears. Arbitration resumes from whatever `prio_q_i` holds after reset.

## Timing
- Reset values: `grant_o = 000`, `busy_o = 0`, `timeout_o = 0`, `prio_en_o = 0`, state IDLE, hold counter 0.
- Request-to-grant latency: request seen in IDLE at cycle N gives a grant visible from cycle N+1.
- Release-to-next-grant: release sampled at edge E; `grant_o = 000` for the cycle after E; next grant appears one edge later. Minimum 2-cycle spacing between grant starts.
- `prio_en_o` is high only in IDLE cycles with a pending request, i.e. exactly once per grant issued.
- Hold counter: 8 bits, cleared on entry to GRANT, increments each GRANT cycle.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - If a grant has been high for `MAX_HOLD` cycles with no release, state returns to IDLE at the next edge.
  - `timeout_o` pulses high for that one IDLE cycle.
  - The revoked requester's mask bit is already cleared, so the next grant favours the other requesters.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built; `timeout_o` = 0 constant.
  - A grant is held until explicit or implicit release.

## Test plan
- Reset: hold `rst = 0` with `req_i = 111` -> `grant_o = 000`, `prio_en_o = 0`, `busy_o = 0`. Release reset -> grant `001` issued one cycle later.
- Rotation: `req_i = 111`, mask register starts 111, `release_i` pulsed 2 cycles after each grant -> grants `001`, `010`, `100`, `001` in order. `prio_d_o` at each strobe = 110, 100, 111, 110. One `000` cycle between grants.
- Masked empty: `prio_q_i = 011`, `req_i = 100` -> grant `100`, `prio_d_o = 011`. Then `req_i = 001` with `prio_q_i = 011` -> grant `001`, `prio_d_o = 010`.
- Implicit release: grant `010` held, drop `req_i[1]` with `release_i = 0` -> `grant_o = 000` next cycle, no `timeout_o`.
- Timeout (macro on, `MAX_HOLD = 4`): `req_i = 011`, no release -> `001` for exactly 4 cycles, `timeout_o` high 1 cycle, then grant `010`. Release asserted on the 4th cycle instead -> `timeout_o` stays 0. With the macro off, the grant is still held after 20 cycles.
- Async reset mid-grant: drop `rst` between edges while `grant_o = 100` -> `grant_o = 000` before the next edge, state IDLE.

Source files
------------

// File: rtl/arbiter_fsm_if.sv
// Request/grant/priority-mask bundle between the arbiter control FSM and its environment.
// The slave side is the arbiter. The master side drives requests and holds the priority register.
interface arbiter_fsm_if;
  localparam int unsigned N_REQ = 3;

  logic [N_REQ-1:0] req_i;
  logic             release_i;
  logic [N_REQ-1:0] prio_q_i;
  logic [N_REQ-1:0] grant_o;
  logic             busy_o;
  logic [N_REQ-1:0] prio_d_o;
  logic             prio_en_o;
  logic             timeout_o;

  modport master (
    output req_i, release_i, prio_q_i,
    input  grant_o, busy_o, prio_d_o, prio_en_o, timeout_o
  );

  modport slave (
    input  req_i, release_i, prio_q_i,
    output grant_o, busy_o, prio_d_o, prio_en_o, timeout_o
  );
endinterface

// File: rtl/arbiter_fsm.sv
// Control stage of the 3-requester round-robin arbiter: registered one-hot grants plus priority-mask update.
// Optional grant watchdog (MAX_HOLD cycles) is built when ARB_TIMEOUT_EN is defined.
module arbiter_fsm #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic          clk,
  input logic          rst,
  arbiter_fsm_if.slave bus
);
  localparam int unsigned N_REQ  = 3;
  localparam int unsigned HOLD_W = 8;
  localparam logic [N_REQ-1:0] ALL_ELIG = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] grant_nxt;
  logic             busy_q;
  logic             timeout_q;
  logic             timeout_nxt;

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] sel;
  logic [N_REQ-1:0] prio_base;
  logic [N_REQ-1:0] prio_clr;
  logic             req_any;
  logic             release_hit;
  logic             timeout_hit;

  assign req_any = |bus.req_i;

  // A dropped request bit of the current holder counts as a release.
  assign release_hit = bus.release_i || ((bus.req_i & grant_q) == '0);

  // Lowest eligible requester; when none is eligible start a fresh round over all requesters.
  always_comb begin
    masked    = bus.req_i & bus.prio_q_i;
    prio_base = ALL_ELIG;
    sel       = bus.req_i & (~bus.req_i + N_REQ'(1));
    if (masked != '0) begin
      prio_base = bus.prio_q_i;
      sel       = masked & (~masked + N_REQ'(1));
    end
    prio_clr = prio_base & ~sel;
  end

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;

  // Counts grant cycles; zero on the first cycle of every grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt != '1) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign timeout_hit = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  max_hold_legal: assert property (@(posedge clk) (MAX_HOLD >= 2) && (MAX_HOLD <= 255));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grants always pass through IDLE; there is no direct GRANT-to-GRANT hand-off.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = GRANT;
      GRANT:   if (release_hit || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Release has priority over timeout, so the pulse only fires on a true watchdog revoke.
  always_comb begin
    grant_nxt     = grant_q;
    timeout_nxt   = 1'b0;
    bus.prio_en_o = 1'b0;
    bus.prio_d_o  = (prio_clr == '0) ? ALL_ELIG : prio_clr;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (req_any) begin
          grant_nxt     = sel;
          bus.prio_en_o = rst;
        end
      end
      GRANT: begin
        if (release_hit) begin
          grant_nxt = '0;
        end else if (timeout_hit) begin
          grant_nxt   = '0;
          timeout_nxt = 1'b1;
        end
      end
      default: grant_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      grant_q   <= grant_nxt;
      busy_q    <= (state_nxt == GRANT);
      timeout_q <= timeout_nxt;
    end
  end

  assign bus.grant_o   = grant_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = timeout_q;
endmodule

// File: tb/tb_arbiter_fsm.sv
// Self-checking bench for arbiter_fsm: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural arbiter model. Honours ARB_TIMEOUT_EN when defined.
module tb_arbiter_fsm;
  localparam int unsigned MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       rel;
  logic       prio_ext;
  logic [2:0] prio_force;
  logic [2:0] prio_reg;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  arbiter_fsm_if bus ();

  arbiter_fsm #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.req_i     = req;
  assign bus.release_i = rel;
  assign bus.prio_q_i  = prio_reg;

  // Priority register owned by the environment; can be overridden to set up scenarios.
  always @(posedge clk or negedge rst) begin
    if (!rst)               prio_reg <= 3'b111;
    else if (prio_ext)      prio_reg <= prio_force;
    else if (bus.prio_en_o) prio_reg <= bus.prio_d_o;
  end

  function automatic int pick(input logic [2:0] r, input logic [2:0] p);
    logic [2:0] pool;
    pool = ((r & p) != 3'b000) ? (r & p) : r;
    for (int k = 0; k < 3; k++) if (pool[k]) return k;
    return -1;
  endfunction

  function automatic logic [2:0] next_mask(input logic [2:0] r, input logic [2:0] p);
    logic [2:0] m;
    int k;
    k = pick(r, p);
    m = ((r & p) != 3'b000) ? p : 3'b111;
    if (k >= 0) m[2'(k)] = 1'b0;
    return (m == 3'b000) ? 3'b111 : m;
  endfunction

  function automatic logic [2:0] onehot(input int g);
    logic [2:0] v;
    v = 3'b000;
    if (g >= 0) v[2'(g)] = 1'b1;
    return v;
  endfunction

  // Behavioural model: index of current holder (-1 = none), cycles held, timeout pulse.
  int m_gnt;
  int m_hold;
  bit m_to;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_gnt  <= -1;
      m_hold <= 0;
      m_to   <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_gnt < 0) begin
        if (req != 3'b000) begin
          m_gnt  <= pick(req, prio_reg);
          m_hold <= 1;
        end
      end else if (rel || !req[2'(m_gnt)]) begin
        m_gnt <= -1;
      end else if (TIMEOUT_ON && m_hold >= int'(MAX_HOLD)) begin
        m_gnt <= -1;
        m_to  <= 1'b1;
      end else begin
        m_hold <= m_hold + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    logic exp_en;
    exp_en = (m_gnt < 0) && (req != 3'b000) && (rst === 1'b1);
    chk("grant",   8'(bus.grant_o),   8'(onehot(m_gnt)));
    chk("busy",    8'(bus.busy_o),    8'(m_gnt >= 0));
    chk("timeout", 8'(bus.timeout_o), 8'(m_to));
    chk("prio_en", 8'(bus.prio_en_o), 8'(exp_en));
    if (exp_en) chk("prio_d", 8'(bus.prio_d_o), 8'(next_mask(req, prio_reg)));
  endtask

  // One clock: model compare on the falling edge, return 2 time units after the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #2;
  endtask

  // Entered in an IDLE cycle: check the strobe, the grant, hold it, release it, check the gap.
  task automatic serve(input logic [2:0] r, input logic [2:0] exp_g, input logic [2:0] exp_d,
                       input int hold);
    req = r;
    rel = 1'b0;
    #1;
    chk("strobe_en", 8'(bus.prio_en_o), 8'd1);
    chk("strobe_d",  8'(bus.prio_d_o),  8'(exp_d));
    step();
    #1;
    chk("serve_grant", 8'(bus.grant_o), 8'(exp_g));
    repeat (hold - 1) step();
    rel = 1'b1;
    step();
    rel = 1'b0;
    #1;
    chk("serve_gap", 8'(bus.grant_o), 8'd0);
  endtask

  initial begin
    rst        = 1'b0;
    req        = 3'b111;
    rel        = 1'b0;
    prio_ext   = 1'b0;
    prio_force = 3'b111;

    // Reset held with all requests pending.
    repeat (3) step();
    #1;
    chk("rst_grant", 8'(bus.grant_o),   8'd0);
    chk("rst_en",    8'(bus.prio_en_o), 8'd0);
    chk("rst_busy",  8'(bus.busy_o),    8'd0);
    rst = 1'b1;

    // Rotation through all three requesters and back.
    serve(3'b111, 3'b001, 3'b110, 2);
    serve(3'b111, 3'b010, 3'b100, 2);
    serve(3'b111, 3'b100, 3'b111, 2);
    serve(3'b111, 3'b001, 3'b110, 2);

    // No request: IDLE holds without a strobe.
    req = 3'b000;
    #1;
    chk("idle_no_req", 8'(bus.prio_en_o), 8'd0);

    // Eligible set empty for the requester, then a masked hit.
    prio_ext   = 1'b1;
    prio_force = 3'b011;
    step();
    serve(3'b100, 3'b100, 3'b011, 2);
    serve(3'b001, 3'b001, 3'b010, 2);
    prio_ext = 1'b0;

    // Implicit release by dropping the holder's request.
    prio_ext   = 1'b1;
    prio_force = 3'b010;
    req        = 3'b000;
    step();
    prio_ext = 1'b0;
    req      = 3'b010;
    #1;
    chk("impl_strobe_d", 8'(bus.prio_d_o), 8'b111);
    step();
    #1;
    chk("impl_grant", 8'(bus.grant_o), 8'b010);
    step();
    req = 3'b000;
    step();
    #1;
    chk("impl_drop",    8'(bus.grant_o),   8'd0);
    chk("impl_no_tout", 8'(bus.timeout_o), 8'd0);

    // Long hold: watchdog revoke when built, indefinite hold otherwise.
    prio_ext   = 1'b1;
    prio_force = 3'b111;
    step();
    prio_ext = 1'b0;
    req      = 3'b011;
`ifdef ARB_TIMEOUT_EN
    step();
    #1;
    chk("tout_hold", 8'(bus.grant_o), 8'b001);
    for (int i = 1; i < int'(MAX_HOLD); i++) begin
      step();
      #1;
      chk("tout_hold", 8'(bus.grant_o), 8'b001);
    end
    step();
    #1;
    chk("tout_revoke", 8'(bus.grant_o),   8'd0);
    chk("tout_pulse",  8'(bus.timeout_o), 8'd1);
    step();
    #1;
    chk("tout_next",     8'(bus.grant_o),   8'b010);
    chk("tout_pulse_end", 8'(bus.timeout_o), 8'd0);
    rel = 1'b1;
    step();
    rel = 1'b0;
    step();
    #1;
    chk("tout_rel_grant", 8'(bus.grant_o), 8'b001);
    for (int i = 2; i < int'(MAX_HOLD); i++) step();
    step();
    rel = 1'b1;
    step();
    rel = 1'b0;
    #1;
    chk("tout_rel_wins", 8'(bus.timeout_o), 8'd0);
    chk("tout_rel_idle", 8'(bus.grant_o),   8'd0);
`else
    step();
    #1;
    chk("hold_grant", 8'(bus.grant_o), 8'b001);
    repeat (20) step();
    #1;
    chk("hold_20",      8'(bus.grant_o),   8'b001);
    chk("hold_no_tout", 8'(bus.timeout_o), 8'd0);
    rel = 1'b1;
    step();
    rel = 1'b0;
`endif

    // Asynchronous reset between edges while 100 is granted.
    req        = 3'b000;
    prio_ext   = 1'b1;
    prio_force = 3'b100;
    step();
    prio_ext = 1'b0;
    req      = 3'b100;
    step();
    #1;
    chk("areset_pre", 8'(bus.grant_o), 8'b100);
    rst = 1'b0;
    #1;
    chk("areset_grant", 8'(bus.grant_o), 8'd0);
    chk("areset_busy",  8'(bus.busy_o),  8'd0);
    step();
    rst = 1'b1;
    req = 3'b000;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
      rel        = ($urandom_range(0, 4) == 0);
      prio_ext   = ($urandom_range(0, 9) == 0);
      prio_force = 3'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
